// File: rtl/wb_tgt_ram.sv
// wb_tgt_ram -- pipelined Wishbone target backed by a small byte-writable RAM.
//
// Requests are queued in order (up to DEPTH). Each queue head waits WAIT
// cycles and then gets exactly one response cycle. Words at or beyond
// MEM_WORDS answer with an error. Memory is read asynchronously.
//
// Handshake: a request is taken at a rising edge where
// tgt_cyc_i & tgt_stb_i & ~tgt_stall_o. The master never waits on a ready
// signal for responses. Ack or err is a single-cycle pulse per queued entry,
// and it only appears while tgt_cyc_i is high. Dropping tgt_cyc_i abandons
// every outstanding request.
//
// Ports:
//   clk_i        module clock
//   async_rst_i  asynchronous active-low reset (clears queue and memory)
//   tgt_cyc_i    bus cycle
//   tgt_stb_i    request strobe
//   tgt_we_i     write enable
//   tgt_sel_i    byte selects
//   tgt_adr_i    word address
//   tgt_dat_i    write data
//   tgt_tga_i    address tag
//   tgt_ack_o    normal termination
//   tgt_err_o    error termination (address out of range)
//   tgt_rty_o    retry, always 0
//   tgt_stall_o  queue full
//   tgt_dat_o    read data
//   tgt_tgd_o    read data tag (echo of the request's tga)

module wb_tgt_ram #(
  parameter int ADR_WIDTH = 4,
  parameter int DAT_WIDTH = 16,
  parameter int SEL_WIDTH = 2,
  parameter int TGA_WIDTH = 1,
  parameter int MEM_WORDS = 12,
  parameter int DEPTH     = 2,
  parameter int WAIT      = 1
) (
  input  logic                 clk_i,
  input  logic                 async_rst_i,
  input  logic                 tgt_cyc_i,
  input  logic                 tgt_stb_i,
  input  logic                 tgt_we_i,
  input  logic [SEL_WIDTH-1:0] tgt_sel_i,
  input  logic [ADR_WIDTH-1:0] tgt_adr_i,
  input  logic [DAT_WIDTH-1:0] tgt_dat_i,
  input  logic [TGA_WIDTH-1:0] tgt_tga_i,
  output logic                 tgt_ack_o,
  output logic                 tgt_err_o,
  output logic                 tgt_rty_o,
  output logic                 tgt_stall_o,
  output logic [DAT_WIDTH-1:0] tgt_dat_o,
  output logic [TGA_WIDTH-1:0] tgt_tgd_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]   C_DEPTH     = CNT_W'(DEPTH);
  localparam logic [2:0]         C_WAIT      = 3'(WAIT);
  localparam logic [ADR_WIDTH:0] C_MEM_WORDS = (ADR_WIDTH + 1)'(MEM_WORDS);

  // Request queue storage (no reset needed: validity comes from r_count).
  logic                 r_q_we  [DEPTH];
  logic [SEL_WIDTH-1:0] r_q_sel [DEPTH];
  logic [ADR_WIDTH-1:0] r_q_adr [DEPTH];
  logic [DAT_WIDTH-1:0] r_q_dat [DEPTH];
  logic [TGA_WIDTH-1:0] r_q_tga [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_wait_cnt;

  logic [DAT_WIDTH-1:0] r_mem [MEM_WORDS];

  logic                 w_full;
  logic                 w_nonempty;
  logic                 w_push;
  logic                 w_resp;
  logic                 w_head_bad;
  logic                 w_ack;
  logic                 w_err;
  logic                 w_wr_en;
  logic                 w_head_we;
  logic [SEL_WIDTH-1:0] w_head_sel;
  logic [ADR_WIDTH-1:0] w_head_adr;
  logic [DAT_WIDTH-1:0] w_head_dat;
  logic [TGA_WIDTH-1:0] w_head_tga;

  assign w_full     = (r_count == C_DEPTH);
  assign w_nonempty = (r_count != '0);
  assign w_push     = tgt_cyc_i & tgt_stb_i & ~w_full;

  assign w_head_we  = r_q_we[r_rd_ptr];
  assign w_head_sel = r_q_sel[r_rd_ptr];
  assign w_head_adr = r_q_adr[r_rd_ptr];
  assign w_head_dat = r_q_dat[r_rd_ptr];
  assign w_head_tga = r_q_tga[r_rd_ptr];

  // The head is answered once its wait counter reaches WAIT. Gating with the
  // reset input keeps every output at zero the instant reset asserts.
  assign w_resp     = async_rst_i & tgt_cyc_i & w_nonempty & (r_wait_cnt == C_WAIT);
  assign w_head_bad = ({1'b0, w_head_adr} >= C_MEM_WORDS);
  assign w_ack      = w_resp & ~w_head_bad;
  assign w_err      = w_resp & w_head_bad;
  assign w_wr_en    = w_ack & w_head_we;

  assign tgt_ack_o   = w_ack;
  assign tgt_err_o   = w_err;
  assign tgt_rty_o   = 1'b0;
  // Stall reflects occupancy only; a pop in the same cycle does not lower it.
  assign tgt_stall_o = w_full & async_rst_i;
  assign tgt_dat_o   = (w_ack & ~w_head_we) ? r_mem[w_head_adr] : '0;
  assign tgt_tgd_o   = w_resp ? w_head_tga : '0;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_we[r_wr_ptr]  <= tgt_we_i;
      r_q_sel[r_wr_ptr] <= tgt_sel_i;
      r_q_adr[r_wr_ptr] <= tgt_adr_i;
      r_q_dat[r_wr_ptr] <= tgt_dat_i;
      r_q_tga[r_wr_ptr] <= tgt_tga_i;
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wait_cnt <= '0;
    end else if (!tgt_cyc_i) begin
      // End of bus cycle: abandon everything outstanding.
      r_rd_ptr   <= r_wr_ptr;
      r_count    <= '0;
      r_wait_cnt <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_resp) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_resp})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_resp) begin
        r_wait_cnt <= '0;
      end else if (w_nonempty && (r_wait_cnt < C_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      for (int k = 0; k < SEL_WIDTH; k++) begin
        if (w_head_sel[k]) begin
          r_mem[w_head_adr][8*k +: 8] <= w_head_dat[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_tgt_ram.sv
module tb_wb_tgt_ram;

  localparam int ADR_WIDTH = 4;
  localparam int DAT_WIDTH = 16;
  localparam int SEL_WIDTH = 2;
  localparam int TGA_WIDTH = 1;
  localparam int MEM_WORDS = 12;
  localparam int DEPTH     = 2;
  localparam int WAIT      = 1;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk_i = 1'b0;
  logic                 async_rst_i;
  logic                 tgt_cyc_i;
  logic                 tgt_stb_i;
  logic                 tgt_we_i;
  logic [SEL_WIDTH-1:0] tgt_sel_i;
  logic [ADR_WIDTH-1:0] tgt_adr_i;
  logic [DAT_WIDTH-1:0] tgt_dat_i;
  logic [TGA_WIDTH-1:0] tgt_tga_i;
  logic                 tgt_ack_o;
  logic                 tgt_err_o;
  logic                 tgt_rty_o;
  logic                 tgt_stall_o;
  logic [DAT_WIDTH-1:0] tgt_dat_o;
  logic [TGA_WIDTH-1:0] tgt_tgd_o;

  always #5 clk_i = ~clk_i;

  wb_tgt_ram #(
    .ADR_WIDTH(ADR_WIDTH), .DAT_WIDTH(DAT_WIDTH), .SEL_WIDTH(SEL_WIDTH),
    .TGA_WIDTH(TGA_WIDTH), .MEM_WORDS(MEM_WORDS), .DEPTH(DEPTH), .WAIT(WAIT)
  ) dut (
    .clk_i(clk_i), .async_rst_i(async_rst_i),
    .tgt_cyc_i(tgt_cyc_i), .tgt_stb_i(tgt_stb_i), .tgt_we_i(tgt_we_i),
    .tgt_sel_i(tgt_sel_i), .tgt_adr_i(tgt_adr_i), .tgt_dat_i(tgt_dat_i),
    .tgt_tga_i(tgt_tga_i), .tgt_ack_o(tgt_ack_o), .tgt_err_o(tgt_err_o),
    .tgt_rty_o(tgt_rty_o), .tgt_stall_o(tgt_stall_o), .tgt_dat_o(tgt_dat_o),
    .tgt_tgd_o(tgt_tgd_o)
  );

  // ---------------- reference model ----------------
  // Pending requests in order; the head becomes answerable WAIT cycles after
  // the cycle in which it became head (head_since).
  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [3:0]  adr;
    logic [15:0] dat;
    logic        tga;
  } req_t;

  req_t        pq[$];
  logic [15:0] m_mem [16];
  int          t;
  int          head_since;
  logic [15:0] last_dat;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
    head_since = 0;
  endtask

  function automatic req_t mk(input logic we, input logic [1:0] sel, input logic [3:0] adr,
                              input logic [15:0] dat, input logic tga);
    req_t r;
    r.we = we; r.sel = sel; r.adr = adr; r.dat = dat; r.tga = tga;
    return r;
  endfunction

  task automatic chk_outputs_zero(input string pfx);
    check_eq({pfx, "_ack"},   32'(tgt_ack_o),   32'd0);
    check_eq({pfx, "_err"},   32'(tgt_err_o),   32'd0);
    check_eq({pfx, "_rty"},   32'(tgt_rty_o),   32'd0);
    check_eq({pfx, "_stall"}, 32'(tgt_stall_o), 32'd0);
    check_eq({pfx, "_dat"},   32'(tgt_dat_o),   32'd0);
    check_eq({pfx, "_tgd"},   32'(tgt_tgd_o),   32'd0);
  endtask

  // ---------------- driver: one bus cycle ----------------
  // Called at posedge+1; drives inputs, checks outputs at the falling edge,
  // then advances the model across the next rising edge.
  task automatic drive_cycle(input logic cyc, input logic stb, input req_t r);
    req_t        h;
    logic        e_resp;
    logic        e_bad;
    logic        e_stall;
    logic [15:0] e_dat;
    logic        e_tgd;
    logic        was_empty;
    logic        popped;
    tgt_cyc_i = cyc;
    tgt_stb_i = stb;
    tgt_we_i  = r.we;
    tgt_sel_i = r.sel;
    tgt_adr_i = r.adr;
    tgt_dat_i = r.dat;
    tgt_tga_i = r.tga;
    @(negedge clk_i);
    e_stall = (pq.size() == DEPTH);
    e_resp  = cyc && (pq.size() != 0) && (t >= head_since + WAIT);
    e_bad   = 1'b0;
    e_dat   = 16'h0000;
    e_tgd   = 1'b0;
    if (e_resp) begin
      h     = pq[0];
      e_bad = (h.adr >= MEM_WORDS);
      e_tgd = h.tga;
      if (!e_bad && !h.we) e_dat = m_mem[h.adr];
    end
    check_eq("ack",   32'(tgt_ack_o),   32'(e_resp && !e_bad));
    check_eq("err",   32'(tgt_err_o),   32'(e_resp && e_bad));
    check_eq("rty",   32'(tgt_rty_o),   32'd0);
    check_eq("stall", 32'(tgt_stall_o), 32'(e_stall));
    check_eq("dat",   32'(tgt_dat_o),   32'(e_dat));
    check_eq("tgd",   32'(tgt_tgd_o),   32'(e_tgd));
    if (tgt_ack_o) last_dat = tgt_dat_o;
    @(posedge clk_i);
    t++;
    if (!cyc) begin
      pq.delete();
    end else begin
      was_empty = (pq.size() == 0);
      popped    = 1'b0;
      if (e_resp) begin
        h = pq.pop_front();
        popped = 1'b1;
        if (!e_bad && h.we) begin
          for (int k = 0; k < 2; k++)
            if (h.sel[k]) m_mem[h.adr][8*k +: 8] = h.dat[8*k +: 8];
        end
      end
      if (stb && !e_stall) pq.push_back(r);
      if (popped || was_empty) head_since = t;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, mk(1'b0, 2'b00, 4'h0, 16'h0, 1'b0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    t = 0;
    last_dat = 16'h0;
    model_reset();
    async_rst_i = 1'b0;
    tgt_cyc_i = 1'b0; tgt_stb_i = 1'b0; tgt_we_i = 1'b0;
    tgt_sel_i = '0; tgt_adr_i = '0; tgt_dat_i = '0; tgt_tga_i = '0;
    #2;
    chk_outputs_zero("rst");
    repeat (2) @(posedge clk_i);
    #1 async_rst_i = 1'b1;

    // Write then read back a full word.
    drive_cycle(1'b1, 1'b1, mk(1'b1, 2'b11, 4'd3, 16'hA5C3, 1'b0));
    idle(3);
    last_dat = 16'hDEAD;
    drive_cycle(1'b1, 1'b1, mk(1'b0, 2'b11, 4'd3, 16'h0000, 1'b1));
    idle(3);
    check_eq("rd_adr3", 32'(last_dat), 32'h0000A5C3);

    // Partial byte-lane write merges with the earlier word.
    drive_cycle(1'b1, 1'b1, mk(1'b1, 2'b11, 4'd5, 16'h1234, 1'b0));
    drive_cycle(1'b1, 1'b1, mk(1'b1, 2'b01, 4'd5, 16'hFFFF, 1'b1));
    idle(4);
    last_dat = 16'hDEAD;
    drive_cycle(1'b1, 1'b1, mk(1'b0, 2'b11, 4'd5, 16'h0000, 1'b0));
    idle(3);
    check_eq("rd_adr5_merge", 32'(last_dat), 32'h000012FF);

    // Back-to-back strobes fill the queue and exercise stall.
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b1, 1'b1, mk(1'b0, 2'b11, 4'(i), 16'h0, 1'(i)));
    idle(6);

    // Out-of-range read and write return err; memory stays untouched.
    drive_cycle(1'b1, 1'b1, mk(1'b0, 2'b11, 4'd13, 16'h0, 1'b1));
    idle(3);
    drive_cycle(1'b1, 1'b1, mk(1'b1, 2'b11, 4'd14, 16'hBEEF, 1'b0));
    idle(3);

    // Dropping cyc before the first response abandons both requests.
    drive_cycle(1'b1, 1'b1, mk(1'b1, 2'b11, 4'd6, 16'h6666, 1'b0));
    drive_cycle(1'b1, 1'b1, mk(1'b1, 2'b11, 4'd7, 16'h7777, 1'b1));
    drive_cycle(1'b0, 1'b1, mk(1'b1, 2'b11, 4'd8, 16'h8888, 1'b0));
    drive_cycle(1'b1, 1'b1, mk(1'b0, 2'b11, 4'd6, 16'h0, 1'b1));
    idle(4);

    // Reset in the middle of a burst with two requests pending.
    drive_cycle(1'b1, 1'b1, mk(1'b1, 2'b11, 4'd3, 16'hBEEF, 1'b0));
    drive_cycle(1'b1, 1'b1, mk(1'b1, 2'b11, 4'd4, 16'hCAFE, 1'b1));
    #3 async_rst_i = 1'b0;
    #1 chk_outputs_zero("midrst");
    model_reset();
    @(posedge clk_i);
    t++;
    #1;
    tgt_cyc_i = 1'b1; tgt_stb_i = 1'b0;
    async_rst_i = 1'b1;
    idle(3);
    last_dat = 16'hDEAD;
    drive_cycle(1'b1, 1'b1, mk(1'b0, 2'b11, 4'd3, 16'h0, 1'b0));
    idle(3);
    check_eq("rd_after_rst", 32'(last_dat), 32'h00000000);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive_cycle(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
                  mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)),
                     1'($urandom_range(0, 1))));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
